// File: rtl/zap_shift_pipe.sv
// zap_shift_pipe -- two-stage pipelined ARM-compatible barrel shifter.
//
// S1 registers the operand, carry, tag, shift type, the decoded amount class
// (zero / 1..W-1 / W / above W) and the amount mod W. S2 forms the shifted
// result and carry from the S1 registers and registers them onto the outputs.
// Results appear on the outputs after the second edge following acceptance.
//
// Optional feature macro: ZAP_SHIFT_RRX_EN
//   defined   : RRX code is a native rotate-through-carry, ROR #0 is a
//               register-form passthrough that keeps the old carry.
//   undefined : ROR #0 performs RRX, the RRX code is an amount-0 passthrough.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_valid, i_stall       operation present / downstream stall (freezes both stages)
//   i_clear                pipeline flush, drops in-flight ops and the current input
//   i_source, i_amount     operand and shift amount
//   i_carry                current CPSR C (used by RRX)
//   i_shift_type           LSL=0 LSR=1 ASR=2 ROR=3 RORI=4 RRX=5
//   i_tag                  sideband, passed through unchanged
//   o_valid, o_result      stage-2 valid and shifted value
//   o_carry                shifter carry-out
//   o_use_old_carry        ALU should keep the existing C
//   o_tag                  tag belonging to o_result
module zap_shift_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int AMT_WIDTH  = 8,
  parameter int SHIFT_OPS  = 6,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_valid,
  input  logic                         i_stall,
  input  logic                         i_clear,
  input  logic [DATA_WIDTH-1:0]        i_source,
  input  logic [AMT_WIDTH-1:0]         i_amount,
  input  logic                         i_carry,
  input  logic [$clog2(SHIFT_OPS)-1:0] i_shift_type,
  input  logic [TAG_WIDTH-1:0]         i_tag,
  output logic                         o_valid,
  output logic [DATA_WIDTH-1:0]        o_result,
  output logic                         o_carry,
  output logic                         o_use_old_carry,
  output logic [TAG_WIDTH-1:0]         o_tag
);

  localparam int W      = DATA_WIDTH;
  localparam int LW     = $clog2(DATA_WIDTH);
  localparam int TW     = $clog2(SHIFT_OPS);
  localparam int STAGES = 2;

  localparam logic [TW-1:0] SH_LSL  = TW'(0);
  localparam logic [TW-1:0] SH_LSR  = TW'(1);
  localparam logic [TW-1:0] SH_ASR  = TW'(2);
  localparam logic [TW-1:0] SH_ROR  = TW'(3);
  localparam logic [TW-1:0] SH_RORI = TW'(4);
  localparam logic [TW-1:0] SH_RRX  = TW'(5);

`ifdef ZAP_SHIFT_RRX_EN
  localparam bit RRX_NATIVE = 1'b1;
`else
  localparam bit RRX_NATIVE = 1'b0;
`endif

  typedef enum logic [1:0] {AMT_ZERO, AMT_IN, AMT_EQ, AMT_ABOVE} amt_cls_e;

  // valid shift register: [1] = S1 valid, [STAGES] = output valid
  logic [STAGES:1]  vld_pipe_q, vld_pipe_d;

  logic [W-1:0]     s1_src_q,   s1_src_d;
  logic             s1_carry_q, s1_carry_d;
  logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
  logic [TW-1:0]    s1_type_q,  s1_type_d;
  amt_cls_e         s1_cls_q,   s1_cls_d;
  logic [LW-1:0]    s1_amt_q,   s1_amt_d;

  logic [W-1:0]     res_q, res_d;
  logic             cry_q, cry_d;
  logic             uoc_q, uoc_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;

  // ---------------- S1 amount decode ----------------
  logic [31:0] amt_ext;
  amt_cls_e    amt_cls;

  always_comb begin
    amt_ext = 32'(i_amount);
    if (amt_ext == 32'd0)         amt_cls = AMT_ZERO;
    else if (amt_ext < 32'(W))    amt_cls = AMT_IN;
    else if (amt_ext == 32'(W))   amt_cls = AMT_EQ;
    else                          amt_cls = AMT_ABOVE;
  end

  // ---------------- S2 shift datapath ----------------
  logic [LW-1:0] neg_amt, amt_m1;
  logic [W-1:0]  rot, rrx;
  logic          msb;
  logic [W-1:0]  sh_res;
  logic          sh_cry, sh_uoc;

  always_comb begin
    // W - amt and amt - 1 wrap naturally in LW bits for amounts 1..W-1
    neg_amt = '0 - s1_amt_q;
    amt_m1  = s1_amt_q - LW'(1);
    msb     = s1_src_q[W-1];
    // left term collapses onto src when amt mod W is zero
    rot     = (s1_src_q >> s1_amt_q) | (s1_src_q << neg_amt);
    rrx     = {s1_carry_q, s1_src_q[W-1:1]};

    sh_res = s1_src_q;
    sh_cry = 1'b0;
    sh_uoc = 1'b0;

    case (s1_type_q)
      SH_LSL: begin
        case (s1_cls_q)
          AMT_ZERO:  sh_uoc = 1'b1;
          AMT_IN:    begin sh_res = s1_src_q << s1_amt_q; sh_cry = s1_src_q[neg_amt]; end
          AMT_EQ:    begin sh_res = '0; sh_cry = s1_src_q[0]; end
          default:   sh_res = '0;
        endcase
      end
      SH_LSR: begin
        case (s1_cls_q)
          AMT_ZERO:  sh_uoc = 1'b1;
          AMT_IN:    begin sh_res = s1_src_q >> s1_amt_q; sh_cry = s1_src_q[amt_m1]; end
          AMT_EQ:    begin sh_res = '0; sh_cry = msb; end
          default:   sh_res = '0;
        endcase
      end
      SH_ASR: begin
        case (s1_cls_q)
          AMT_ZERO:  sh_uoc = 1'b1;
          AMT_IN:    begin sh_res = $signed(s1_src_q) >>> s1_amt_q; sh_cry = s1_src_q[amt_m1]; end
          default:   begin sh_res = {W{msb}}; sh_cry = msb; end
        endcase
      end
      SH_ROR: begin
        if (s1_cls_q == AMT_ZERO) begin
          if (RRX_NATIVE) sh_uoc = 1'b1;
          else begin sh_res = rrx; sh_cry = s1_src_q[0]; end
        end else if (s1_amt_q == '0) begin
          sh_cry = msb;
        end else begin
          sh_res = rot;
          sh_cry = rot[W-1];
        end
      end
      SH_RORI: begin
        if (s1_cls_q == AMT_ZERO) sh_uoc = 1'b1;
        else begin sh_res = rot; sh_cry = rot[W-1]; end
      end
      SH_RRX: begin
        if (RRX_NATIVE) begin sh_res = rrx; sh_cry = s1_src_q[0]; end
        else sh_uoc = 1'b1;
      end
      default: sh_uoc = 1'b1;
    endcase
  end

  // ---------------- next-state: clear > stall > advance ----------------
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_src_d   = s1_src_q;
    s1_carry_d = s1_carry_q;
    s1_tag_d   = s1_tag_q;
    s1_type_d  = s1_type_q;
    s1_cls_d   = s1_cls_q;
    s1_amt_d   = s1_amt_q;
    res_d      = res_q;
    cry_d      = cry_q;
    uoc_d      = uoc_q;
    tag_d      = tag_q;
    if (i_clear) begin
      vld_pipe_d = '0;
    end else if (!i_stall) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], i_valid};
      s1_src_d   = i_source;
      s1_carry_d = i_carry;
      s1_tag_d   = i_tag;
      s1_type_d  = i_shift_type;
      s1_cls_d   = amt_cls;
      s1_amt_d   = amt_ext[LW-1:0];
      res_d      = sh_res;
      cry_d      = sh_cry;
      uoc_d      = sh_uoc;
      tag_d      = s1_tag_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_pipe_q <= '0;
      s1_src_q   <= '0;
      s1_carry_q <= 1'b0;
      s1_tag_q   <= '0;
      s1_type_q  <= '0;
      s1_cls_q   <= AMT_ZERO;
      s1_amt_q   <= '0;
      res_q      <= '0;
      cry_q      <= 1'b0;
      uoc_q      <= 1'b0;
      tag_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_src_q   <= s1_src_d;
      s1_carry_q <= s1_carry_d;
      s1_tag_q   <= s1_tag_d;
      s1_type_q  <= s1_type_d;
      s1_cls_q   <= s1_cls_d;
      s1_amt_q   <= s1_amt_d;
      res_q      <= res_d;
      cry_q      <= cry_d;
      uoc_q      <= uoc_d;
      tag_q      <= tag_d;
    end
  end

  assign o_valid         = vld_pipe_q[STAGES];
  assign o_result        = res_q;
  assign o_carry         = cry_q;
  assign o_use_old_carry = uoc_q;
  assign o_tag           = tag_q;

endmodule

// File: tb/tb_zap_shift_pipe.sv
// Self-checking bench for zap_shift_pipe (W=32). Expected results come from a
// shift model written from the ARM shift rules; pipeline timing is tracked as
// a queue of accepted ops, each due on the outputs once two unstalled edges
// have passed since it was taken.
module tb_zap_shift_pipe;
  localparam int W = 32;

  logic        clk = 1'b0;
  logic        i_reset, i_valid, i_stall, i_clear, i_carry;
  logic [31:0] i_source;
  logic [7:0]  i_amount;
  logic [2:0]  i_shift_type;
  logic [5:0]  i_tag;
  logic        o_valid, o_carry, o_use_old_carry;
  logic [31:0] o_result;
  logic [5:0]  o_tag;

  always #5 clk = ~clk;

  zap_shift_pipe dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
    .i_clear(i_clear), .i_source(i_source), .i_amount(i_amount),
    .i_carry(i_carry), .i_shift_type(i_shift_type), .i_tag(i_tag),
    .o_valid(o_valid), .o_result(o_result), .o_carry(o_carry),
    .o_use_old_carry(o_use_old_carry), .o_tag(o_tag)
  );

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        uo;
    logic [5:0]  tag;
    int          adv;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;

  function automatic logic [31:0] rotr(logic [31:0] s, int k);
    if (k == 0) return s;
    return (s >> k) | (s << (W - k));
  endfunction

  function automatic exp_t model(logic [31:0] s, int a, logic cin, int typ, logic [5:0] tag);
    exp_t e;
    logic [31:0] t;
    int k;
    k = a % W;
    e.res = s; e.c = 1'b0; e.uo = 1'b0; e.tag = tag; e.adv = 0;
    case (typ)
      0: if (a == 0) e.uo = 1'b1;
         else if (a < W) begin e.res = s << a; t = s >> (W - a); e.c = t[0]; end
         else if (a == W) begin e.res = '0; e.c = s[0]; end
         else e.res = '0;
      1: if (a == 0) e.uo = 1'b1;
         else if (a < W) begin e.res = s >> a; t = s >> (a - 1); e.c = t[0]; end
         else if (a == W) begin e.res = '0; e.c = s[W-1]; end
         else e.res = '0;
      2: if (a == 0) e.uo = 1'b1;
         else if (a < W) begin
           e.res = (s >> a) | (s[W-1] ? ~(32'hFFFF_FFFF >> a) : 32'h0);
           t = s >> (a - 1); e.c = t[0];
         end else begin e.res = {W{s[W-1]}}; e.c = s[W-1]; end
      3: if (a == 0) begin
`ifdef ZAP_SHIFT_RRX_EN
           e.uo = 1'b1;
`else
           e.res = {cin, s[W-1:1]}; e.c = s[0];
`endif
         end else if (k == 0) e.c = s[W-1];
         else begin e.res = rotr(s, k); e.c = e.res[W-1]; end
      4: if (a == 0) e.uo = 1'b1;
         else begin e.res = rotr(s, k); e.c = e.res[W-1]; end
      5: begin
`ifdef ZAP_SHIFT_RRX_EN
           e.res = {cin, s[W-1:1]}; e.c = s[0];
`else
           e.uo = 1'b1;
`endif
         end
      default: e.uo = 1'b1;
    endcase
    return e;
  endfunction

  // Advance the timing model by one clock edge using the inputs as driven.
  function automatic void model_edge();
    exp_t e;
    if (i_reset || i_clear) begin q.delete(); return; end
    if (i_stall) return;
    foreach (q[j]) q[j].adv++;
    while (q.size() > 0 && q[0].adv > 2) void'(q.pop_front());
    if (i_valid) begin
      e = model(i_source, int'(i_amount), i_carry, int'(i_shift_type), i_tag);
      e.adv = 1;
      q.push_back(e);
    end
  endfunction

  function automatic bit exp_valid();
    return q.size() > 0 && q[0].adv == 2;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_op(input bit v);
    int sel;
    i_valid      = v;
    i_source     = $urandom;
    i_carry      = 1'($urandom_range(0, 1));
    i_shift_type = 3'($urandom_range(0, 5));
    i_tag        = 6'($urandom);
    sel = $urandom_range(0, 5);
    case (sel)
      0: i_amount = 8'd0;
      1: i_amount = 8'd1;
      2: i_amount = 8'($urandom_range(1, 31));
      3: i_amount = 8'd32;
      4: i_amount = 8'($urandom_range(33, 255));
      default: i_amount = 8'd31;
    endcase
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    rand_op(1'b1);
    step(); step();
    checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", o_valid); else passes++;
    checks++; if (o_result !== 32'h0) $display("FAIL reset_result got %h exp 0", o_result); else passes++;
    checks++; if (o_carry !== 1'b0) $display("FAIL reset_carry got %b exp 0", o_carry); else passes++;
    checks++; if (o_use_old_carry !== 1'b0) $display("FAIL reset_use_old got %b exp 0", o_use_old_carry); else passes++;
    checks++; if (o_tag !== 6'h0) $display("FAIL reset_tag got %h exp 0", o_tag); else passes++;
    i_reset = 1'b0; i_valid = 1'b0;
    step();
  endtask

  typedef struct {
    logic [2:0] typ; logic [31:0] src; logic [7:0] amt; logic cin;
    logic [31:0] res; logic c; logic uo;
  } dir_t;

  task automatic test_directed();
    dir_t v[13];
    v[0]  = '{3'd0, 32'h8000_0001, 8'd1,  1'b0, 32'h0000_0002, 1'b1, 1'b0};
    v[1]  = '{3'd0, 32'h8000_0001, 8'd32, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    v[2]  = '{3'd0, 32'h8000_0001, 8'd33, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    v[3]  = '{3'd0, 32'h8000_0001, 8'd0,  1'b1, 32'h8000_0001, 1'b0, 1'b1};
    v[4]  = '{3'd2, 32'h8000_0000, 8'd40, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    v[5]  = '{3'd1, 32'h8000_0000, 8'd32, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    v[6]  = '{3'd1, 32'h8000_0000, 8'd31, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    v[7]  = '{3'd3, 32'h0000_00F1, 8'd4,  1'b1, 32'h1000_000F, 1'b0, 1'b0};
    v[8]  = '{3'd3, 32'h0000_00F1, 8'd32, 1'b1, 32'h0000_00F1, 1'b0, 1'b0};
`ifdef ZAP_SHIFT_RRX_EN
    v[9]  = '{3'd3, 32'h0000_00F1, 8'd0,  1'b1, 32'h0000_00F1, 1'b0, 1'b1};
    v[10] = '{3'd5, 32'h0000_00F1, 8'd0,  1'b1, 32'h8000_0078, 1'b1, 1'b0};
`else
    v[9]  = '{3'd3, 32'h0000_00F1, 8'd0,  1'b1, 32'h8000_0078, 1'b1, 1'b0};
    v[10] = '{3'd5, 32'h0000_00F1, 8'd0,  1'b1, 32'h0000_00F1, 1'b0, 1'b1};
`endif
    v[11] = '{3'd4, 32'h8000_0001, 8'd1,  1'b0, 32'hC000_0000, 1'b1, 1'b0};
    v[12] = '{3'd2, 32'h8000_0010, 8'd4,  1'b0, 32'hF800_0001, 1'b0, 1'b0};
    i_stall = 1'b0; i_clear = 1'b0;
    for (int i = 0; i < 13; i++) begin
      i_valid = 1'b1; i_shift_type = v[i].typ; i_source = v[i].src;
      i_amount = v[i].amt; i_carry = v[i].cin; i_tag = 6'(i + 1);
      step();
      i_valid = 1'b0;
      checks++; if (o_valid !== 1'b0) $display("FAIL dir%0d_early_valid got %b exp 0", i, o_valid); else passes++;
      step();
      checks++; if (o_valid !== 1'b1) $display("FAIL dir%0d_valid got %b exp 1", i, o_valid); else passes++;
      checks++; if (o_result !== v[i].res) $display("FAIL dir%0d_result got %h exp %h", i, o_result, v[i].res); else passes++;
      checks++; if (o_carry !== v[i].c) $display("FAIL dir%0d_carry got %b exp %b", i, o_carry, v[i].c); else passes++;
      checks++; if (o_use_old_carry !== v[i].uo) $display("FAIL dir%0d_use_old got %b exp %b", i, o_use_old_carry, v[i].uo); else passes++;
      checks++; if (o_tag !== 6'(i + 1)) $display("FAIL dir%0d_tag got %h exp %h", i, o_tag, 6'(i + 1)); else passes++;
    end
    step();
  endtask

  task automatic test_random();
    bit ev;
    for (int n = 0; n < 400; n++) begin
      rand_op($urandom_range(0, 3) != 0);
      i_stall = ($urandom_range(0, 4) == 0);
      i_clear = ($urandom_range(0, 29) == 0);
      step();
      ev = exp_valid();
      checks++; if (o_valid !== ev) $display("FAIL rnd%0d_valid got %b exp %b", n, o_valid, ev); else passes++;
      if (ev) begin
        checks++;
        if (o_result !== q[0].res || o_carry !== q[0].c || o_use_old_carry !== q[0].uo || o_tag !== q[0].tag)
          $display("FAIL rnd%0d_data got %h/%b/%b/%h exp %h/%b/%b/%h", n, o_result, o_carry,
                   o_use_old_carry, o_tag, q[0].res, q[0].c, q[0].uo, q[0].tag);
        else passes++;
      end
    end
    i_stall = 1'b0; i_clear = 1'b0; i_valid = 1'b0;
    step(); step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev_res; logic [5:0] prev_tag; logic prev_v;
    bit st, ev;
    int k = 0;
    int seen = 0;
    for (int c = 0; c < 20; c++) begin
      st = (c >= 3 && c < 6);
      i_stall = st; i_clear = 1'b0;
      if (k < 8) begin
        if (!(c > 3 && c < 6)) rand_op(1'b1);  // upstream holds inputs across the stall
        i_tag = 6'(16 + k);
      end else i_valid = 1'b0;
      prev_res = o_result; prev_tag = o_tag; prev_v = o_valid;
      step();
      if (!st && k < 8) k++;
      ev = exp_valid();
      checks++; if (o_valid !== ev) $display("FAIL b2b%0d_valid got %b exp %b", c, o_valid, ev); else passes++;
      if (ev) begin
        checks++;
        if (o_result !== q[0].res || o_carry !== q[0].c || o_use_old_carry !== q[0].uo)
          $display("FAIL b2b%0d_data got %h/%b/%b exp %h/%b/%b", c, o_result, o_carry,
                   o_use_old_carry, q[0].res, q[0].c, q[0].uo);
        else passes++;
      end
      if (st) begin
        checks++;
        if (o_valid !== prev_v || o_result !== prev_res || o_tag !== prev_tag)
          $display("FAIL b2b%0d_hold got %b/%h/%h exp %b/%h/%h", c, o_valid, o_result, o_tag,
                   prev_v, prev_res, prev_tag);
        else passes++;
      end else if (o_valid) begin
        checks++; if (o_tag !== 6'(16 + seen)) $display("FAIL b2b%0d_order got %h exp %h", c, o_tag, 6'(16 + seen)); else passes++;
        seen++;
      end
    end
    checks++; if (seen != 8) $display("FAIL b2b_count got %0d exp 8", seen); else passes++;
  endtask

  task automatic test_clear();
    i_stall = 1'b0; i_clear = 1'b0;
    rand_op(1'b1); step();
    rand_op(1'b1); step();
    checks++; if (o_valid !== 1'b1) $display("FAIL clr_fill_valid got %b exp 1", o_valid); else passes++;
    i_stall = 1'b1; i_clear = 1'b1; rand_op(1'b1);
    step();
    checks++; if (o_valid !== 1'b0) $display("FAIL clr_valid got %b exp 0", o_valid); else passes++;
    i_stall = 1'b0; i_clear = 1'b0; i_valid = 1'b0;
    step();
    checks++; if (o_valid !== 1'b0) $display("FAIL clr_s1_flushed got %b exp 0", o_valid); else passes++;
    step();
    checks++; if (o_valid !== 1'b0) $display("FAIL clr_drained got %b exp 0", o_valid); else passes++;
  endtask

  task automatic test_reset_mid();
    i_stall = 1'b0; i_clear = 1'b0;
    rand_op(1'b1); i_shift_type = 3'd4; i_amount = 8'd5; i_source = 32'hDEAD_BEEF; step();
    rand_op(1'b1); step();
    i_stall = 1'b1; step();
    checks++; if (o_valid !== 1'b1) $display("FAIL rstm_pre_valid got %b exp 1", o_valid); else passes++;
    i_reset = 1'b1;
    step();
    checks++; if (o_valid !== 1'b0) $display("FAIL rstm_valid got %b exp 0", o_valid); else passes++;
    checks++; if (o_result !== 32'h0) $display("FAIL rstm_result got %h exp 0", o_result); else passes++;
    checks++; if (o_carry !== 1'b0) $display("FAIL rstm_carry got %b exp 0", o_carry); else passes++;
    checks++; if (o_use_old_carry !== 1'b0) $display("FAIL rstm_use_old got %b exp 0", o_use_old_carry); else passes++;
    checks++; if (o_tag !== 6'h0) $display("FAIL rstm_tag got %h exp 0", o_tag); else passes++;
    i_reset = 1'b0; i_stall = 1'b0; i_valid = 1'b0;
    step();
    checks++; if (o_valid !== 1'b0) $display("FAIL rstm_s1_flushed got %b exp 0", o_valid); else passes++;
  endtask

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_stall = 1'b0; i_clear = 1'b0; i_carry = 1'b0;
    i_source = '0; i_amount = '0; i_shift_type = '0; i_tag = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/zap_shift_pipe.md
# zap_shift_pipe

Two-stage pipelined, width-parametrised ARM-compatible barrel shifter for the ZAP shift stage. It replaces the single-cycle combinational shifter between the issue and ALU stages. It adds a valid/stall/flush handshake, a sideband tag, and full ARM amount-saturation rules for any data width. It also supports an optional native RRX mode. Results and carry flags reach the ALU two cycles after acceptance.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; power of two, at least 8.
- AMT_WIDTH, 8, shift-amount width (bottom byte of Rs).
- SHIFT_OPS, 6, number of shift-type codes (codes from shtype.vh: LSL, LSR, ASR, ROR, RORI, RRX).
- TAG_WIDTH, 6, sideband tag width (destination index), passed through unchanged.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  operation present on inputs.
- i_stall  in  1  downstream stall; freezes both stages.
- i_clear  in  1  pipeline flush (branch/exception).
- i_source  in  DATA_WIDTH  operand.
- i_amount  in  AMT_WIDTH  shift amount.
- i_carry  in  1  current CPSR C, sampled with operand.
- i_shift_type  in  $clog2(SHIFT_OPS)  shift code.
- i_tag  in  TAG_WIDTH  sideband.
- o_valid  out  1  stage-2 output valid.
- o_result  out  DATA_WIDTH  shifted value.
- o_carry  out  1  shifter carry-out.
- o_use_old_carry  out  1  ALU keeps existing C.
- o_tag  out  TAG_WIDTH  tag of o_result.

## Operation
- Stage 1 (S1) registers operand, carry, tag, type, valid. It also registers the decoded amount class: zero, in-range (1..W-1), equal W, above W. It registers rotate amount mod W. W = DATA_WIDTH.
- Stage 2 (S2) computes the result from S1 registers and registers o_result, o_carry, o_use_old_carry, o_tag, o_valid.
- Amount 0 for LSL, LSR, ASR, RORI: result = source, carry = 0, o_use_old_carry = 1.
- LSL, amount 1..W-1: carry = src[W-amt]. Amount W: result 0, carry src[0]. Amount above W: result 0, carry 0.
- LSR, amount 1..W-1: carry = src[amt-1]. Amount W: result 0, carry src[W-1]. Amount above W: result 0, carry 0.
- ASR, amount 1..W-1: carry = src[amt-1]. Amount W or more: result = W copies of src[W-1], carry = src[W-1].
- ROR, nonzero amount with amt mod W = 0: result = source, carry = src[W-1]. Other nonzero amounts: rotate right by amt mod W, carry = result[W-1].
- RORI, nonzero amount: rotate right by amt mod W, carry = result[W-1].
- ROR and RRX at amount 0: see Configuration.
- o_use_old_carry = 0 except where stated above.
- Bubbles (valid 0) propagate. Data registers of a bubble may hold any value, but o_valid must be 0.

## Timing
- Reset values: o_valid 0, o_result 0, o_carry 0, o_use_old_carry 0, o_tag 0. S1 valid is also 0.
- Latency: an input accepted at edge N (i_valid=1, i_stall=0) appears on the outputs after edge N+1.
- Throughput: 1 per cycle while i_stall=0.
- Stall: while i_stall=1, S1 and S2 hold every register, including valid. Inputs are not accepted, so upstream must hold them.
- Clear: i_clear=1 zeroes S1 and S2 valid at the next edge, and the input in that cycle is dropped. Data registers may hold any value.
- Priority: i_reset > i_clear > i_stall > normal advance.
- Reset or clear asserted mid-stall discards all in-flight operations. No operation is ever duplicated or reordered.

## Configuration
- ZAP_SHIFT_RRX_EN defined:
  - RRX code: result = {i_carry, src[W-1:1]}, carry = src[0], o_use_old_carry = 0.
  - ROR with amount 0 is register-form per ARM: result = source, o_use_old_carry = 1.
- ZAP_SHIFT_RRX_EN undefined (legacy-compatible):
  - ROR with amount 0 performs RRX as above.
  - The RRX code behaves as amount-0 passthrough: result = source, o_use_old_carry = 1.

## Test plan
- LSL, W=32, src 0x8000_0001: amount 1 -> 0x0000_0002, C=1. Amount 32 -> 0, C=1. Amount 33 -> 0, C=0.
- ASR, src 0x8000_0000, amount 40 -> 0xFFFF_FFFF, C=1. LSR same src, amount 32 -> 0, C=1. Each output exactly 2 cycles after acceptance, o_tag matching.
- ROR, src 0x0000_00F1, i_carry=1: amount 4 -> 0x1000_000F, C=0. Amount 32 -> 0x0000_00F1, C=0.
- Amount 0: ROR with macro on -> result 0x0000_00F1, use_old=1. With macro off -> 0x8000_0078, C=1. RRX code -> same contrast, reversed per Configuration.
- Back-to-back stream of 8 ops with i_stall=1 for 3 cycles mid-stream: outputs in order, none lost or duplicated, held values stable during the stall.
- i_clear together with i_stall while both stages are valid: o_valid=0 next cycle. Reset mid-stream: all outputs return to their reset values after one edge.
